spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_controller_if.sv | 16 +
 rtl/spi_half_period_timer.sv | 19 +
 rtl/spi_controller.sv | 88 ++++++++
 tb/tb_spi_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared constants, register map and FSM state type for the SPI write controller
// and for anything that talks to the peripheral register file.
package spi_pkg;
  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam logic WRITE_FLAG = 1'b1;

  localparam logic [ADDR_W-1:0] EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] PWM_DUTY    = 7'h04;

  typedef enum logic [2:0] {
    IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP
  } state_t;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [ADDR_W-1:0] addr,
                                                     input logic [DATA_W-1:0] data);
    return {WRITE_FLAG, addr, data};
  endfunction
endpackage

// File: rtl/spi_controller_if.sv
// Request/status bus between a requester (master) and the SPI controller (slave).
interface spi_controller_if;
  import spi_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              busy;
  logic              done;

  modport master (output req_valid, req_addr, req_data,
                  input  req_ready, busy, done);
  modport slave  (input  req_valid, req_addr, req_data,
                  output req_ready, busy, done);
endinterface

// File: rtl/spi_half_period_timer.sv
// Counts HALF_PERIOD clk cycles and pulses o_tick on the last one; restartable.
module spi_half_period_timer #(
  parameter int HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_restart,
  output logic o_tick
);
  logic [7:0] r_cnt;

  assign o_tick = (r_cnt == 8'(HALF_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (i_restart || o_tick) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 8'd1;
  end
endmodule

// File: rtl/spi_controller.sv
// Write-only SPI master: sends {1, addr[6:0], data[7:0]} MSB first, mode 0,
// with SCLK half-period of HALF_PERIOD clk cycles and registered pin outputs.
module spi_controller
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             sclk,
  output logic             copi,
  output logic             cs_n
);
  state_t               r_state, w_state_nxt;
  logic [3:0]           r_bit_cnt;
  logic [FRAME_W-1:0]   r_shift;
  logic                 r_sclk, r_cs_n, r_done;
  logic                 w_tick, w_accept, w_restart;
  logic                 w_sclk_d, w_cs_n_d, w_done_d;

  assign w_accept      = bus.req_valid && bus.req_ready;
  assign w_restart     = (w_state_nxt != r_state);
  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;
  assign sclk          = r_sclk;
  assign cs_n          = r_cs_n;
  assign copi          = r_shift[FRAME_W-1];

  spi_half_period_timer #(.HALF_PERIOD(HALF_PERIOD)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_accept) w_state_nxt = SETUP;
      SETUP:    if (w_tick)   w_state_nxt = SHIFT_HI;
      SHIFT_HI: if (w_tick)   w_state_nxt = (r_bit_cnt == 4'd15) ? HOLD : SHIFT_LO;
      SHIFT_LO: if (w_tick)   w_state_nxt = SHIFT_HI;
      HOLD:     if (w_tick)   w_state_nxt = GAP;
      GAP:      if (w_tick)   w_state_nxt = IDLE;
      default:                w_state_nxt = IDLE;
    endcase
  end

  // Pin values are decoded from the upcoming state so they land in flops.
  always_comb begin
    w_sclk_d = (w_state_nxt == SHIFT_HI);
    w_cs_n_d = (w_state_nxt == IDLE) || (w_state_nxt == GAP);
    w_done_d = (r_state == HOLD) && (w_state_nxt == GAP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk <= 1'b0;
      r_cs_n <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_sclk <= w_sclk_d;
      r_cs_n <= w_cs_n_d;
      r_done <= w_done_d;
    end
  end

  // Shifting on every high-phase exit also clears copi after the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= build_frame(bus.req_addr, bus.req_data);
      r_bit_cnt <= '0;
    end else if (r_state == SHIFT_HI && w_tick) begin
      r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (H=4 and H=2), a timeline model,
// and a behavioural SPI register peripheral on each instance's pins.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rv = '0;
  logic [6:0] ra [2];
  logic [7:0] rd [2];
  logic [1:0] sclk_w, copi_w, cs_n_w, rdy_w, busy_w, done_w;

  spi_controller_if u_if0 ();
  spi_controller_if u_if1 ();

  assign u_if0.req_valid = rv[0];
  assign u_if0.req_addr  = ra[0];
  assign u_if0.req_data  = rd[0];
  assign u_if1.req_valid = rv[1];
  assign u_if1.req_addr  = ra[1];
  assign u_if1.req_data  = rd[1];
  assign rdy_w  = {u_if1.req_ready, u_if0.req_ready};
  assign busy_w = {u_if1.busy, u_if0.busy};
  assign done_w = {u_if1.done, u_if0.done};

  spi_controller #(.HALF_PERIOD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(u_if0.slave),
    .sclk(sclk_w[0]), .copi(copi_w[0]), .cs_n(cs_n_w[0]));
  spi_controller #(.HALF_PERIOD(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(u_if1.slave),
    .sclk(sclk_w[1]), .copi(copi_w[1]), .cs_n(cs_n_w[1]));

  int ntot = 0;
  int nbad = 0;

  function automatic int hp(int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic check(string name, int act, int exp);
    ntot++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Timeline model: t = clk edges since accept (0 = idle); a frame spans 34H edges.
  int t [2] = '{0, 0};
  logic [15:0] mframe [2];
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) t[i] <= 0;
      else if (t[i] == 0 && rv[i]) begin
        t[i]      <= 1;
        mframe[i] <= {1'b1, ra[i], rd[i]};
      end else if (t[i] > 0 && t[i] < 34 * hp(i)) t[i] <= t[i] + 1;
      else t[i] <= 0;
    end
  end

  // Peripheral state, one set per instance.
  logic [1:0]  prev_cs = 2'b11;
  logic [1:0]  prev_sclk = 2'b00;
  logic [15:0] shreg [2];
  logic [15:0] lastf [2];
  int rises [2] = '{0, 0};
  int cslow [2] = '{0, 0};
  int hi_cnt [2] = '{0, 0};
  int last_gap [2] = '{0, 0};
  int done_cnt [2] = '{0, 0};
  logic [7:0] regs [2][5] = '{default: '0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int h, tt, p, e_copi;
      h  = hp(i);
      tt = t[i];
      p  = (tt > 0) ? (tt - 1) / h : 0;
      e_copi = (tt >= 1 && p <= 31) ? int'(mframe[i][15 - p / 2]) : 0;
      check($sformatf("u%0d.busy", i),  int'(busy_w[i]), int'(tt >= 1));
      check($sformatf("u%0d.ready", i), int'(rdy_w[i]),  int'(tt == 0));
      check($sformatf("u%0d.cs_n", i),  int'(cs_n_w[i]), int'(!(tt >= 1 && tt <= 33 * h)));
      check($sformatf("u%0d.sclk", i),  int'(sclk_w[i]),
            int'(tt >= 1 && p >= 1 && p <= 31 && (p % 2) == 1));
      check($sformatf("u%0d.copi", i),  int'(copi_w[i]), e_copi);
      check($sformatf("u%0d.done", i),  int'(done_w[i]), int'(tt == 33 * h + 1));

      if (!cs_n_w[i]) begin
        if (prev_cs[i]) begin
          rises[i]    <= 0;
          done_cnt[i] <= 0;
          last_gap[i] <= hi_cnt[i];
        end
        cslow[i] <= prev_cs[i] ? 1 : cslow[i] + 1;
        if (sclk_w[i] && !prev_sclk[i]) begin
          shreg[i] <= {shreg[i][14:0], copi_w[i]};
          rises[i] <= rises[i] + 1;
        end
      end else begin
        if (!prev_cs[i]) begin
          lastf[i] <= shreg[i];
          if (rises[i] == 16 && shreg[i][15] && shreg[i][14:8] < 7'd5)
            regs[i][int'(shreg[i][14:8])] <= shreg[i][7:0];
        end
        hi_cnt[i] <= prev_cs[i] ? hi_cnt[i] + 1 : 1;
        if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
      end
      prev_cs[i]   <= cs_n_w[i];
      prev_sclk[i] <= sclk_w[i];
    end
  end

  task automatic send(int i, logic [6:0] a, logic [7:0] d, bit keep);
    int n;
    n = 0;
    rv[i] = 1'b1;
    ra[i] = a;
    rd[i] = d;
    do begin
      @(posedge clk); #1; n++;
    end while (t[i] != 1 && n < 2000);
    check($sformatf("u%0d.accept", i), t[i], 1);
    if (!keep) rv[i] = 1'b0;
  endtask

  task automatic wait_idle(int i);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (t[i] != 0 && n < 2000);
    check($sformatf("u%0d.idle", i), t[i], 0);
    @(negedge clk); #1;
  endtask

  initial begin
    int n;
    logic [7:0] exp_regs [5];
    ra[0] = '0; rd[0] = '0; ra[1] = '0; rd[1] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single write right after reset release, H=4.
    send(0, 7'h04, 8'h80, 1'b0);
    wait_idle(0);
    check("f1.frame", int'(lastf[0]), 16'h8480);
    check("f1.cs_low", cslow[0], 132);
    check("f1.rises", rises[0], 16);
    check("f1.done_cnt", done_cnt[0], 1);

    send(0, 7'h00, 8'hF0, 1'b0); wait_idle(0);
    send(0, 7'h01, 8'h0F, 1'b0); wait_idle(0);
    send(0, 7'h02, 8'hAA, 1'b0); wait_idle(0);
    send(0, 7'h03, 8'h55, 1'b0); wait_idle(0);
    exp_regs = '{8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h80};
    for (int k = 0; k < 5; k++) check($sformatf("loop.reg%0d", k), int'(regs[0][k]), int'(exp_regs[k]));

    // Back-to-back with valid held high.
    send(0, 7'h00, 8'hF0, 1'b1);
    send(0, 7'h01, 8'h0F, 1'b0);
    wait_idle(0);
    check("b2b.gap", last_gap[0], 5);
    check("b2b.frame", int'(lastf[0]), 16'h810F);

    // Reset after the fifth sclk rise.
    send(0, 7'h00, 8'h12, 1'b0);
    n = 0;
    while (rises[0] != 5 && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    check("rst.rises", rises[0], 5);
    rst_n = 1'b0;
    #1;
    check("rst.cs_n", int'(cs_n_w[0]), 1);
    check("rst.sclk", int'(sclk_w[0]), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst.reg0_kept", int'(regs[0][0]), 8'hF0);
    send(0, 7'h03, 8'h66, 1'b0);
    wait_idle(0);
    check("rst.next_frame", int'(lastf[0]), 16'h8366);
    check("rst.next_reg3", int'(regs[0][3]), 8'h66);

    // Unmapped address: full frame, nothing written.
    send(0, 7'h05, 8'hFF, 1'b0);
    wait_idle(0);
    check("unmap.frame", int'(lastf[0]), 16'h85FF);
    check("unmap.rises", rises[0], 16);
    exp_regs = '{8'hF0, 8'h0F, 8'hAA, 8'h66, 8'h80};
    for (int k = 0; k < 5; k++) check($sformatf("unmap.reg%0d", k), int'(regs[0][k]), int'(exp_regs[k]));

    // H=2 instance.
    send(1, 7'h02, 8'h3C, 1'b0);
    wait_idle(1);
    check("h2.frame", int'(lastf[1]), 16'h823C);
    check("h2.cs_low", cslow[1], 66);
    check("h2.rises", rises[1], 16);
    check("h2.reg2", int'(regs[1][2]), 8'h3C);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", ntot, nbad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", ntot, nbad);
    $fatal(1, "watchdog");
  end
endmodule
